aes_pipe_drain_ctrl: RTL
========================

# aes_pipe_drain_ctrl

Output-side flow controller for the 40-stage AES pipeline. It tracks every block pushed into stage 0, marks it valid at the pipeline output exactly PIPE_DEPTH cycles later, and sequences fill → stream → drain so the output packer knows when ciphertext is valid and when the pipeline has fully emptied. It is the consumer-side counterpart of the fill-latency counter and sits between the pipeline input mux and the output packer.

## Interface
Parameters:
- PIPE_DEPTH, 40, pipeline stages between input and output
- CNT_BITS, 6, width of the in-flight counter; must satisfy 2^CNT_BITS > PIPE_DEPTH

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  block enters stage 0 on this rising edge
- in_last  in  1  marks the final block of a message; qualified by in_valid
- flush  in  1  synchronous abort; clears all tracking
- out_valid  out  1  block at pipeline output is valid this cycle
- out_last  out  1  block at output is the message's last block
- inflight  out  CNT_BITS  number of valid blocks currently in the pipeline
- pipe_empty  out  1  inflight == 0
- pipe_full  out  1  inflight == PIPE_DEPTH
- busy  out  1  state != IDLE
- drain_done  out  1  one-cycle pulse: message fully drained
- proto_err  out  1  sticky: in_valid seen while in DRAIN

## Operation
- Valid shift register vsr[0..PIPE_DEPTH-1] plus parallel last register lsr; each edge vsr[0] <= in_valid, lsr[0] <= in_valid & in_last, stage i takes stage i-1.
- out_valid = vsr[PIPE_DEPTH-1]; out_last = lsr[PIPE_DEPTH-1]. Both come straight from flops, no combinational path from inputs.
- inflight_next = inflight + in_valid - out_valid, CNT_BITS unsigned. Invariant: inflight == popcount(vsr). Never wraps, because at most one in and one out per cycle.
- FSM states IDLE, FILL, STREAM, DRAIN. Transitions are evaluated each edge, first match wins:
  - flush=1 → IDLE from any state.
  - IDLE: in_valid & in_last → DRAIN; in_valid → FILL.
  - FILL: in_valid & in_last → DRAIN; out_valid → STREAM.
  - STREAM: in_valid & in_last → DRAIN.
  - DRAIN: inflight_next == 0 → IDLE. drain_done is registered high for the first IDLE cycle only.
- in_valid during DRAIN:
  - the block is still tracked in vsr and inflight;
  - proto_err sets and stays set;
  - the state stays DRAIN until empty.
- Gaps in in_valid during FILL/STREAM are legal and do not change state.
- flush clears vsr, lsr, inflight and the state in one edge. It does not clear proto_err, does not pulse drain_done, and any in_valid that cycle is discarded.
- Reset values: all outputs 0; state IDLE; vsr, lsr, inflight all 0. pipe_empty is combinational and therefore reads 1 out of reset.

## Timing
- Latency: in_valid high in cycle N → out_valid high in cycle N+PIPE_DEPTH, for exactly one cycle per block.
- Back-to-back in_valid for k cycles → out_valid high for k consecutive cycles starting N+PIPE_DEPTH.
- Simultaneous in and out: inflight is unchanged, and pipe_full can hold across a continuous stream.
- Single last block at cycle N from IDLE:
  - DRAIN from N+1;
  - out_valid & out_last at N+40;
  - IDLE and drain_done at N+41.
- Asynchronous reset mid-operation drops every in-flight block with no drain_done pulse.

## Configuration
- PIPE_DRAIN_STATS_EN defined:
  - adds outputs blocks_in[15:0] and blocks_out[15:0], which count accepted in_valid and emitted out_valid;
  - both wrap modulo 2^16;
  - both are cleared by reset and by flush.
- Not defined: these ports and their logic are absent, and all other behaviour is identical.

## Structure
- Shared package aes_pipe_pkg holds:
  - the drain_state_t enum (IDLE, FILL, STREAM, DRAIN);
  - the AES_PIPE_DEPTH = 40 constant, used as the PIPE_DEPTH default;
  - the AES_PIPE_CNT_BITS = 6 constant.
- One sub-module, pipe_valid_shift: a parameterised PIPE_DEPTH×2-bit shift register with synchronous clear, used for vsr and lsr. The FSM, counter and flags live in the top module.

## Test plan
- Reset then idle 50 cycles → all outputs 0 except pipe_empty=1, busy=0.
- Single in_valid+in_last at cycle 10:
  - out_valid=out_last=1 only at cycle 50;
  - drain_done pulse at cycle 51;
  - inflight returns 0.
- 60 consecutive in_valid, last on the 60th:
  - pipe_full=1 from cycle 40 until input stops, with inflight=40;
  - out_valid high for 60 cycles;
  - exactly one drain_done.
- Pattern 1,0,1,1,0 on in_valid → out_valid reproduces 1,0,1,1,0 delayed by 40 cycles; state stays FILL until first out_valid, then STREAM.
- 10 blocks in flight, flush asserted → next cycle inflight=0, state IDLE, no out_valid within 40 cycles, no drain_done.
- in_valid during DRAIN → proto_err=1 and stays set through flush; the extra block still exits; drain_done follows its exit.

Source files
------------

// File: rtl/aes_pipe_pkg.sv
// rtl/aes_pipe_pkg.sv - shared types and constants for the AES pipeline drain controller
package aes_pipe_pkg;

    localparam int AES_PIPE_DEPTH    = 40;
    localparam int AES_PIPE_CNT_BITS = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } drain_state_t;

endpackage

// File: rtl/pipe_valid_shift.sv
// rtl/pipe_valid_shift.sv - PIPE_DEPTH x 2-bit shift register with synchronous clear
//
// Ports:
//   clk    - system clock, rising edge
//   n_rst  - asynchronous active-low reset
//   clr    - synchronous clear of every stage (takes priority over shifting)
//   d      - value entering stage 0
//   q      - value held in the last stage
module pipe_valid_shift
    import aes_pipe_pkg::*;
#(
    parameter int PIPE_DEPTH = AES_PIPE_DEPTH
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clr,
    input  logic [1:0] d,
    output logic [1:0] q
);

    logic [PIPE_DEPTH-1:0][1:0] sr_q;
    logic [PIPE_DEPTH-1:0][1:0] sr_d;

    always_comb begin
        sr_d = '0;
        if (!clr) begin
            sr_d = {sr_q[PIPE_DEPTH-2:0], d};
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q = sr_q[PIPE_DEPTH-1];

endmodule

// File: rtl/aes_pipe_drain_ctrl.sv
// rtl/aes_pipe_drain_ctrl.sv - fill/stream/drain flow controller for the AES pipeline output
//
// Optional feature macro: PIPE_DRAIN_STATS_EN (adds blocks_in / blocks_out counters)
//
// Ports:
//   clk, n_rst          - clock, asynchronous active-low reset
//   in_valid, in_last   - block (and last-of-message marker) entering stage 0
//   flush               - synchronous abort, clears all tracking
//   out_valid, out_last - block at pipeline output is valid / is last of message
//   inflight            - number of valid blocks in the pipeline
//   pipe_empty          - inflight == 0
//   pipe_full           - inflight == PIPE_DEPTH
//   busy                - state is not IDLE
//   drain_done          - one-cycle pulse on the first IDLE cycle after a drain
//   blocks_in/out       - (PIPE_DRAIN_STATS_EN) accepted / emitted block counts, mod 2^16
//   proto_err           - sticky: in_valid seen while draining
module aes_pipe_drain_ctrl
    import aes_pipe_pkg::*;
#(
    parameter int PIPE_DEPTH = AES_PIPE_DEPTH,
    parameter int CNT_BITS   = AES_PIPE_CNT_BITS
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                in_valid,
    input  logic                in_last,
    input  logic                flush,
    output logic                out_valid,
    output logic                out_last,
    output logic [CNT_BITS-1:0] inflight,
    output logic                pipe_empty,
    output logic                pipe_full,
    output logic                busy,
    output logic                drain_done,
`ifdef PIPE_DRAIN_STATS_EN
    output logic [15:0]         blocks_in,
    output logic [15:0]         blocks_out,
`endif
    output logic                proto_err
);

    drain_state_t        state_q, state_d;
    logic [CNT_BITS-1:0] inflight_q, inflight_d, inflight_next;
    logic                drain_done_q, drain_done_d;
    logic                proto_err_q, proto_err_d;
    logic [1:0]          shift_q;

    // bit 0 tracks validity, bit 1 tracks the last marker of a valid block
    pipe_valid_shift #(
        .PIPE_DEPTH(PIPE_DEPTH)
    ) u_shift (
        .clk  (clk),
        .n_rst(n_rst),
        .clr  (flush),
        .d    ({in_valid & in_last, in_valid}),
        .q    (shift_q)
    );

    assign out_valid = shift_q[0];
    assign out_last  = shift_q[1];

    // At most one block in and one out per cycle, so this never wraps.
    assign inflight_next = inflight_q + CNT_BITS'(in_valid) - CNT_BITS'(out_valid);

    always_comb begin
        state_d      = state_q;
        inflight_d   = inflight_next;
        drain_done_d = 1'b0;
        proto_err_d  = proto_err_q;
        if (flush) begin
            state_d    = IDLE;
            inflight_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid && in_last) state_d = DRAIN;
                    else if (in_valid)       state_d = FILL;
                end
                FILL: begin
                    if (in_valid && in_last) state_d = DRAIN;
                    else if (out_valid)      state_d = STREAM;
                end
                STREAM: begin
                    if (in_valid && in_last) state_d = DRAIN;
                end
                DRAIN: begin
                    // Blocks arriving here are still tracked but flag a protocol error.
                    if (in_valid) proto_err_d = 1'b1;
                    if (inflight_next == '0) begin
                        state_d      = IDLE;
                        drain_done_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            inflight_q   <= '0;
            drain_done_q <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            inflight_q   <= inflight_d;
            drain_done_q <= drain_done_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign inflight   = inflight_q;
    assign pipe_empty = (inflight_q == '0);
    assign pipe_full  = (inflight_q == CNT_BITS'(PIPE_DEPTH));
    assign busy       = (state_q != IDLE);
    assign drain_done = drain_done_q;
    assign proto_err  = proto_err_q;

`ifdef PIPE_DRAIN_STATS_EN
    logic [15:0] blocks_in_q, blocks_out_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            blocks_in_q  <= '0;
            blocks_out_q <= '0;
        end else if (flush) begin
            blocks_in_q  <= '0;
            blocks_out_q <= '0;
        end else begin
            blocks_in_q  <= blocks_in_q + 16'(in_valid);
            blocks_out_q <= blocks_out_q + 16'(out_valid);
        end
    end

    assign blocks_in  = blocks_in_q;
    assign blocks_out = blocks_out_q;
`endif

endmodule
